// File: rtl/vliw_regfile.sv
// rtl/vliw_regfile.sv - multi-lane integer register file with bypass, busy scoreboard and write-conflict flag
//
// Purpose: LANES issue lanes, each with two combinational read ports and one
// write port. x0 is hardwired zero and not stored. Reads are write-first
// bypassed; colliding writes resolve to the highest-index lane.
//
// Ports:
//   clk            core clock, rising edge
//   reset          asynchronous active-low reset
//   a1, a2         per-lane read addresses
//   rd1, rd2       per-lane read data (combinational)
//   we3, a3, wd3   per-lane write enable / address / data
//   LongWrW        per-lane: this write retires a long-latency op (clears busy)
//   SetBusyD       per-lane: issue a long-latency op to BusyAdrD (sets busy)
//   BusyAdrD       per-lane destination of that op
//   Busy1D/2D      per-lane: a1/a2 target a busy register
//   BusyWrD        per-lane: a3 targets a busy register
//   WriteConflictW previous cycle had >=2 enabled writes to one legal nonzero register
//   IllegalAdrD    per-lane: any of a1/a2/a3 is >= NUMREGS
`timescale 1ns/1ps

module vliw_regfile #(
  parameter int XLEN    = 64,
  parameter int LANES   = 2,
  parameter int NUMREGS = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [LANES-1:0][4:0]       a1,
  input  logic [LANES-1:0][4:0]       a2,
  output logic [LANES-1:0][XLEN-1:0]  rd1,
  output logic [LANES-1:0][XLEN-1:0]  rd2,
  input  logic [LANES-1:0]            we3,
  input  logic [LANES-1:0][4:0]       a3,
  input  logic [LANES-1:0][XLEN-1:0]  wd3,
  input  logic [LANES-1:0]            LongWrW,
  input  logic [LANES-1:0]            SetBusyD,
  input  logic [LANES-1:0][4:0]       BusyAdrD,
  output logic [LANES-1:0]            Busy1D,
  output logic [LANES-1:0]            Busy2D,
  output logic [LANES-1:0]            BusyWrD,
  output logic                        WriteConflictW,
  output logic [LANES-1:0]            IllegalAdrD
);

  localparam logic [5:0] NR6 = 6'(NUMREGS);

  logic [XLEN-1:0]      regs_q [1:NUMREGS-1];
  logic [XLEN-1:0]      regs_d [1:NUMREGS-1];
  logic [NUMREGS-1:1]   busy_q;
  logic [NUMREGS-1:1]   busy_d;
  logic                 conflict_q;
  logic                 conflict_d;

  function automatic logic legal_nz(input logic [4:0] a);
    return (a != 5'd0) && ({1'b0, a} < NR6);
  endfunction

  // Next state. Lanes are applied in ascending order so the highest-index
  // writer wins. regs_d therefore also equals the write-first bypass value,
  // and the read ports are taken from it directly.
  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    conflict_d = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      for (int r = 1; r < NUMREGS; r++) begin
        if (we3[l] && a3[l] == 5'(r)) regs_d[r] = wd3[l];
      end
    end
    // Clears first, then sets: a new issue is younger than a retiring write.
    for (int l = 0; l < LANES; l++) begin
      for (int r = 1; r < NUMREGS; r++) begin
        if (we3[l] && LongWrW[l] && a3[l] == 5'(r)) busy_d[r] = 1'b0;
      end
    end
    for (int l = 0; l < LANES; l++) begin
      for (int r = 1; r < NUMREGS; r++) begin
        if (SetBusyD[l] && BusyAdrD[l] == 5'(r)) busy_d[r] = 1'b1;
      end
    end
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (we3[i] && we3[j] && a3[i] == a3[j] && legal_nz(a3[i])) conflict_d = 1'b1;
      end
    end
  end

  // Read and busy ports. Address 0 and addresses >= NUMREGS match no entry
  // and fall through to the zero default.
  always_comb begin
    rd1         = '0;
    rd2         = '0;
    Busy1D      = '0;
    Busy2D      = '0;
    BusyWrD     = '0;
    IllegalAdrD = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int r = 1; r < NUMREGS; r++) begin
        if (a1[l] == 5'(r)) begin
          rd1[l]    = regs_d[r];
          Busy1D[l] = busy_q[r];
        end
        if (a2[l] == 5'(r)) begin
          rd2[l]    = regs_d[r];
          Busy2D[l] = busy_q[r];
        end
        if (a3[l] == 5'(r)) BusyWrD[l] = busy_q[r];
      end
      IllegalAdrD[l] = ({1'b0, a1[l]} >= NR6) || ({1'b0, a2[l]} >= NR6) ||
                       ({1'b0, a3[l]} >= NR6);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 1; r < NUMREGS; r++) regs_q[r] <= '0;
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      for (int r = 1; r < NUMREGS; r++) regs_q[r] <= regs_d[r];
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign WriteConflictW = conflict_q;

endmodule

// File: tb/tb_vliw_regfile.sv
// tb/tb_vliw_regfile.sv - scoreboard bench for vliw_regfile against an array reference model
`timescale 1ns/1ps

module tb_vliw_regfile;

  localparam int XL = 64;
  localparam int LN = 2;
  localparam int NR = 16;

  logic                    clk;
  logic                    reset;
  logic [LN-1:0][4:0]      a1, a2, a3, BusyAdrD;
  logic [LN-1:0][XL-1:0]   rd1, rd2, wd3;
  logic [LN-1:0]           we3, LongWrW, SetBusyD;
  logic [LN-1:0]           Busy1D, Busy2D, BusyWrD, IllegalAdrD;
  logic                    WriteConflictW;

  vliw_regfile #(.XLEN(XL), .LANES(LN), .NUMREGS(NR)) dut (
    .clk(clk), .reset(reset),
    .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
    .we3(we3), .a3(a3), .wd3(wd3),
    .LongWrW(LongWrW), .SetBusyD(SetBusyD), .BusyAdrD(BusyAdrD),
    .Busy1D(Busy1D), .Busy2D(Busy2D), .BusyWrD(BusyWrD),
    .WriteConflictW(WriteConflictW), .IllegalAdrD(IllegalAdrD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LN-1:0][XL-1:0] rd1;
    logic [LN-1:0][XL-1:0] rd2;
    logic [LN-1:0]         b1, b2, bw, ill;
    logic                  conf;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  // Reference state: architectural registers, busy bits, pending conflict flag.
  logic [XL-1:0] m_regs [NR];
  logic          m_busy [NR];
  logic          m_conf;

  function automatic bit ok(input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < NR);
  endfunction

  task automatic chk(input string n, input logic [XL-1:0] act, input logic [XL-1:0] want);
    total_cnt++;
    if (act !== want) $display("FAIL %s got %h want %h at %0t", n, act, want, $time);
    else pass_cnt++;
  endtask

  task automatic model_clear();
    for (int r = 0; r < NR; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    m_conf = 1'b0;
  endtask

  // Inputs are already driven. Compute what the outputs must be this cycle,
  // queue it for the monitor, then advance the model across the clock edge.
  task automatic step();
    exp_t          e;
    logic [XL-1:0] nxt [NR];
    int            cnt [NR];
    logic          nb  [NR];
    bit            conf;
    for (int r = 0; r < NR; r++) begin
      nxt[r] = m_regs[r];
      cnt[r] = 0;
      nb[r]  = m_busy[r];
    end
    // Program order: later lanes overwrite earlier ones.
    for (int l = 0; l < LN; l++) begin
      if (we3[l] && ok(a3[l])) begin
        nxt[int'(a3[l])] = wd3[l];
        cnt[int'(a3[l])]++;
      end
    end
    for (int l = 0; l < LN; l++) begin
      e.rd1[l] = ok(a1[l]) ? nxt[int'(a1[l])] : '0;
      e.rd2[l] = ok(a2[l]) ? nxt[int'(a2[l])] : '0;
      e.b1[l]  = ok(a1[l]) ? m_busy[int'(a1[l])] : 1'b0;
      e.b2[l]  = ok(a2[l]) ? m_busy[int'(a2[l])] : 1'b0;
      e.bw[l]  = ok(a3[l]) ? m_busy[int'(a3[l])] : 1'b0;
      e.ill[l] = (int'(a1[l]) >= NR) || (int'(a2[l]) >= NR) || (int'(a3[l]) >= NR);
    end
    e.conf = m_conf;
    exp_q.push_back(e);
    conf = 1'b0;
    for (int r = 1; r < NR; r++) if (cnt[r] >= 2) conf = 1'b1;
    for (int l = 0; l < LN; l++)
      if (we3[l] && LongWrW[l] && ok(a3[l])) nb[int'(a3[l])] = 1'b0;
    for (int l = 0; l < LN; l++)
      if (SetBusyD[l] && ok(BusyAdrD[l])) nb[int'(BusyAdrD[l])] = 1'b1;
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < NR; r++) begin
        m_regs[r] = nxt[r];
        m_busy[r] = nb[r];
      end
      m_conf = conf;
    end
    #1;
  endtask

  task automatic idle();
    we3 = '0; LongWrW = '0; SetBusyD = '0;
    a1 = '0; a2 = '0; a3 = '0; BusyAdrD = '0; wd3 = '0;
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    model_clear();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      for (int l = 0; l < LN; l++) begin
        chk($sformatf("rd1[%0d]", l), rd1[l], e.rd1[l]);
        chk($sformatf("rd2[%0d]", l), rd2[l], e.rd2[l]);
      end
      chk("Busy1D", XL'(Busy1D), XL'(e.b1));
      chk("Busy2D", XL'(Busy2D), XL'(e.b2));
      chk("BusyWrD", XL'(BusyWrD), XL'(e.bw));
      chk("IllegalAdrD", XL'(IllegalAdrD), XL'(e.ill));
      chk("WriteConflictW", XL'(WriteConflictW), XL'(e.conf));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1);
  end

  initial begin
    idle();
    assert_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset held: writes to x5 must not land; reads of other regs are zero.
    we3 = 2'b11; a3[0] = 5'd5; a3[1] = 5'd5; wd3[0] = 64'hFF; wd3[1] = 64'hFF;
    a1[0] = 5'd1; a2[0] = 5'd2; a1[1] = 5'd3; a2[1] = 5'd4;
    step();
    reset = 1'b1;
    step();                                  // first edge after release writes x5
    idle(); a1[0] = 5'd5; step();

    // Bypass then storage.
    we3 = 2'b01; a3[0] = 5'd7; wd3[0] = 64'h1234; a1[1] = 5'd7; step();
    idle(); a1[1] = 5'd7; step();

    // Conflict on x3, then flag drops after one cycle.
    we3 = 2'b11; a3[0] = 5'd3; a3[1] = 5'd3; wd3[0] = 64'hAAAA; wd3[1] = 64'h5555; step();
    idle(); a1[0] = 5'd3; step();
    step();

    // Both lanes write x0: no flag, x0 stays zero.
    we3 = 2'b11; wd3[0] = 64'hDEAD; wd3[1] = 64'hDEAD; step();
    idle(); step();

    // Illegal addresses.
    a1[0] = 5'd20; a2[1] = 5'd16; step();
    idle(); we3 = 2'b01; a3[0] = 5'd20; wd3[0] = 64'hBEEF; a1[1] = 5'd4; step();
    idle(); a1[0] = 5'd4; step();

    // Busy set on x9, retire four cycles later.
    SetBusyD[0] = 1'b1; BusyAdrD[0] = 5'd9; a1[0] = 5'd9; step();
    idle(); a1[0] = 5'd9; a3[1] = 5'd9; repeat (3) step();
    we3[0] = 1'b1; a3[0] = 5'd9; LongWrW[0] = 1'b1; wd3[0] = 64'hC0FFEE; step();
    idle(); a1[0] = 5'd9; step();

    // Set and clear collide: set wins. Then mid-sequence reset.
    SetBusyD[1] = 1'b1; BusyAdrD[1] = 5'd9;
    we3[0] = 1'b1; a3[0] = 5'd9; LongWrW[0] = 1'b1; wd3[0] = 64'h77; step();
    idle(); a1[0] = 5'd9; step();
    assert_reset(); step();
    reset = 1'b1; step();

    // Randomised traffic with occasional asynchronous reset.
    for (int c = 0; c < 2000; c++) begin
      for (int l = 0; l < LN; l++) begin
        a1[l]       = 5'($urandom_range(0, 19));
        a2[l]       = 5'($urandom_range(0, 19));
        a3[l]       = 5'($urandom_range(0, 17));
        BusyAdrD[l] = 5'($urandom_range(0, 17));
        wd3[l]      = {$urandom, $urandom};
        we3[l]      = ($urandom_range(0, 3) != 0);
        LongWrW[l]  = ($urandom_range(0, 2) == 0);
        SetBusyD[l] = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 199) == 0) assert_reset();
      else reset = 1'b1;
      step();
    end

    idle();
    reset = 1'b1;
    step();
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", XL'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
